// File: rtl/alu_op_stepper_if.sv
// Signal bundle between the board switch/button front end and alu_op_stepper.
// The master drives buttons, switches and operands; the slave returns result, flags and step strobe.
interface alu_op_stepper_if #(
  parameter int unsigned BITS = 5
);
  logic            noperSel;
  logic            dir;
  logic            hold;
  logic [BITS-1:0] A;
  logic [BITS-1:0] B;
  logic [3:0]      currentOper;
  logic [BITS-1:0] result;
  logic [3:0]      flags;
  logic            stepPulse;

  modport master (
    output noperSel,
    output dir,
    output hold,
    output A,
    output B,
    input  currentOper,
    input  result,
    input  flags,
    input  stepPulse
  );

  modport slave (
    input  noperSel,
    input  dir,
    input  hold,
    input  A,
    input  B,
    output currentOper,
    output result,
    output flags,
    output stepPulse
  );
endinterface

// File: rtl/alu_op_stepper.sv
// Button-stepped ALU: a debounced press walks an up/down operation counter, and the selected
// operation on A/B is registered together with its NZCV flags unless hold freezes them.
module alu_op_stepper #(
  parameter int unsigned BITS = 5,
  parameter int unsigned NOPS = 8
) (
  input logic             clk,
  input logic             nreset,
  alu_op_stepper_if.slave bus
);

  localparam int unsigned Msb    = BITS - 1;
  localparam logic [2:0]  LastOp = 3'(NOPS - 1);

  typedef enum logic [2:0] {
    OpAdd = 3'd0,
    OpSub = 3'd1,
    OpAnd = 3'd2,
    OpOr  = 3'd3,
    OpXor = 3'd4,
    OpShl = 3'd5,
    OpShr = 3'd6,
    OpNot = 3'd7
  } op_e;

  // ---------------------------------------------------------------------------------------------
  // Button path
  // ---------------------------------------------------------------------------------------------
  logic sync1_q, sync2_q, prev_q;
  logic fill_q;
  logic armed_q, armed_d;
  logic press;
  logic step_q;

  // armed only after a genuinely sampled released level, so a button held through reset is
  // ignored until it has been let go once.
  always_comb begin
    armed_d = armed_q | (fill_q & sync1_q);
    press   = armed_q & prev_q & ~sync2_q;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      fill_q  <= 1'b0;
      armed_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      sync1_q <= bus.noperSel;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fill_q  <= 1'b1;
      armed_q <= armed_d;
      step_q  <= press;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Operation counter
  // ---------------------------------------------------------------------------------------------
  logic [2:0] op_q, op_d;

  always_comb begin
    op_d = op_q;
    if (step_q) begin
      if (bus.dir) begin
        op_d = (op_q == 3'd0) ? LastOp : op_q - 3'd1;
      end else begin
        op_d = (op_q == LastOp) ? 3'd0 : op_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      op_q <= 3'd0;
    end else begin
      op_q <= op_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------------------------
  logic [BITS:0]   sum, diff;
  logic [BITS-1:0] res_d;
  logic            c_d, v_d;
  logic [3:0]      flags_d;

  always_comb begin
    sum   = {1'b0, bus.A} + {1'b0, bus.B};
    diff  = {1'b0, bus.A} - {1'b0, bus.B};
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    unique case (op_e'(op_q))
      OpAdd: begin
        res_d = sum[BITS-1:0];
        c_d   = sum[BITS];
        v_d   = (bus.A[Msb] == bus.B[Msb]) && (sum[Msb] != bus.A[Msb]);
      end
      OpSub: begin
        res_d = diff[BITS-1:0];
        // Top bit of the extended difference is the borrow.
        c_d   = ~diff[BITS];
        v_d   = (bus.A[Msb] != bus.B[Msb]) && (diff[Msb] != bus.A[Msb]);
      end
      OpAnd: res_d = bus.A & bus.B;
      OpOr:  res_d = bus.A | bus.B;
      OpXor: res_d = bus.A ^ bus.B;
      OpShl: begin
        res_d = {bus.A[BITS-2:0], 1'b0};
        c_d   = bus.A[Msb];
      end
      OpShr: begin
        res_d = {1'b0, bus.A[BITS-1:1]};
        c_d   = bus.A[0];
      end
      OpNot: res_d = ~bus.A;
    endcase
    flags_d = {res_d[Msb], (res_d == '0), c_d, v_d};
  end

  logic [BITS-1:0] result_q;
  logic [3:0]      flags_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      result_q <= '0;
      flags_q  <= 4'b0000;
    end else if (!bus.hold) begin
      result_q <= res_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.currentOper = {1'b0, op_q};
  assign bus.result      = result_q;
  assign bus.flags       = flags_q;
  assign bus.stepPulse   = step_q;

endmodule

// File: tb/tb_alu_op_stepper.sv
// Bench for alu_op_stepper: one BITS=5/NOPS=8 and one BITS=5/NOPS=5 instance sharing stimulus,
// checked against an integer-arithmetic model and a table of hand-computed vectors.
module tb_alu_op_stepper;

  localparam int BITS = 5;
  localparam int MOD  = 32;
  localparam int HALF = 16;

  logic clk;
  logic nreset;

  alu_op_stepper_if #(.BITS(BITS)) bus8 ();
  alu_op_stepper_if #(.BITS(BITS)) bus5 ();

  alu_op_stepper #(.BITS(BITS), .NOPS(8)) u_dut8 (.clk(clk), .nreset(nreset), .bus(bus8));
  alu_op_stepper #(.BITS(BITS), .NOPS(5)) u_dut5 (.clk(clk), .nreset(nreset), .bus(bus5));

  assign bus5.noperSel = bus8.noperSel;
  assign bus5.dir      = bus8.dir;
  assign bus5.hold     = bus8.hold;
  assign bus5.A        = bus8.A;
  assign bus5.B        = bus8.B;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int op8    = 0;
  int op5    = 0;

  typedef struct {
    int         op;
    int         a;
    int         b;
    int         res;
    logic [3:0] f;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sgn(input int v);
    return (v >= HALF) ? v - MOD : v;
  endfunction

  function automatic logic out_of_range(input int v);
    return (v < -HALF) || (v > HALF - 1);
  endfunction

  function automatic void model(input int op, input int a, input int b,
                                output int r, output logic [3:0] f);
    int   t;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (op)
      0: begin t = a + b; r = t % MOD; c = (t >= MOD); v = out_of_range(sgn(a) + sgn(b)); end
      1: begin t = a - b; r = (t + MOD) % MOD; c = (a >= b); v = out_of_range(sgn(a) - sgn(b)); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a * 2) % MOD; c = (a >= HALF); end
      6: begin r = a / 2; c = (a % 2) == 1; end
      default: r = MOD - 1 - a;
    endcase
    f = {(r >= HALF), (r == 0), c, v};
  endfunction

  task automatic check_alu(input string tag);
    int         r;
    logic [3:0] f;
    model(op8, int'(bus8.A), int'(bus8.B), r, f);
    check({tag, "_res8"}, bus8.result, r);
    check({tag, "_flg8"}, bus8.flags, f);
    model(op5, int'(bus8.A), int'(bus8.B), r, f);
    check({tag, "_res5"}, bus5.result, r);
    check({tag, "_flg5"}, bus5.flags, f);
  endtask

  task automatic do_reset(input logic btn);
    nreset        = 1'b0;
    bus8.noperSel = btn;
    repeat (3) tick();
    check("rst_op8", bus8.currentOper, 0);
    check("rst_op5", bus5.currentOper, 0);
    check("rst_result", bus8.result, 0);
    check("rst_flags", bus8.flags, 0);
    check("rst_pulse", bus8.stepPulse, 0);
    nreset = 1'b1;
    op8    = 0;
    op5    = 0;
  endtask

  // Button low for hold_cyc sampled edges; the strobe must appear exactly once, 3 edges after
  // the drive point (sampled at edge 1, strobe after edge 3).
  task automatic press(input logic d, input int hold_cyc);
    int first = 0;
    int cnt   = 0;
    bus8.dir      = d;
    bus8.noperSel = 1'b0;
    for (int k = 1; k <= hold_cyc + 6; k++) begin
      tick();
      if (bus8.stepPulse === 1'b1) begin
        cnt++;
        if (first == 0) first = k;
      end
      if (k == hold_cyc) bus8.noperSel = 1'b1;
    end
    op8 = d ? (op8 + 7) % 8 : (op8 + 1) % 8;
    op5 = d ? (op5 + 4) % 5 : (op5 + 1) % 5;
    check("pulse_latency", first, 3);
    check("pulse_count", cnt, 1);
    check("oper8", bus8.currentOper, op8);
    check("oper5", bus5.currentOper, op5);
  endtask

  task automatic goto_op(input int target);
    for (int i = 0; i < 8 && op8 != target; i++) press(1'b0, 2);
  endtask

  initial begin
    int         pulses;
    int         hr;
    logic [3:0] hf;

    vecs[0]  = '{0, 20, 15, 3,  4'b0010};
    vecs[1]  = '{0, 15, 1,  16, 4'b1001};
    vecs[2]  = '{1, 5,  9,  28, 4'b1000};
    vecs[3]  = '{1, 9,  5,  4,  4'b0010};
    vecs[4]  = '{1, 16, 1,  15, 4'b0011};
    vecs[5]  = '{2, 12, 10, 8,  4'b0000};
    vecs[6]  = '{3, 5,  8,  13, 4'b0000};
    vecs[7]  = '{4, 7,  7,  0,  4'b0100};
    vecs[8]  = '{5, 18, 0,  4,  4'b0010};
    vecs[9]  = '{6, 19, 0,  9,  4'b0010};
    vecs[10] = '{7, 10, 0,  21, 4'b1000};

    nreset        = 1'b0;
    bus8.noperSel = 1'b1;
    bus8.dir      = 1'b0;
    bus8.hold     = 1'b0;
    bus8.A        = '0;
    bus8.B        = '0;

    // Button held through reset: no strobe until it is released and pressed again.
    do_reset(1'b0);
    pulses = 0;
    repeat (10) begin
      tick();
      if (bus8.stepPulse === 1'b1) pulses++;
    end
    check("held_after_reset_pulses", pulses, 0);
    check("held_after_reset_op", bus8.currentOper, 0);
    check("held_after_reset_res", bus8.result, 0);
    bus8.noperSel = 1'b1;
    repeat (3) tick();

    // Nine up presses walk 1..7,0,1; one of them held for 50 cycles.
    for (int i = 0; i < 9; i++) press(1'b0, (i == 4) ? 50 : 1 + (i % 4));

    // Down from zero wraps to NOPS-1 on both instances.
    do_reset(1'b1);
    tick();
    press(1'b1, 3);
    check("down_wrap8", bus8.currentOper, 7);
    check("down_wrap5", bus5.currentOper, 4);

    // Reset in the middle of a press discards it.
    bus8.noperSel = 1'b0;
    tick();
    tick();
    do_reset(1'b0);
    pulses = 0;
    repeat (8) begin
      tick();
      if (bus8.stepPulse === 1'b1) pulses++;
    end
    check("midpress_reset_pulses", pulses, 0);
    bus8.noperSel = 1'b1;
    repeat (3) tick();
    press(1'b0, 4);

    // Hand-computed vectors.
    for (int i = 0; i < 11; i++) begin
      goto_op(vecs[i].op);
      bus8.A = 5'(vecs[i].a);
      bus8.B = 5'(vecs[i].b);
      tick();
      check($sformatf("vec%0d_res", i), bus8.result, vecs[i].res);
      check($sformatf("vec%0d_flg", i), bus8.flags, vecs[i].f);
    end

    // Random operands over randomly stepped operations.
    for (int i = 0; i < 10; i++) begin
      press(1'($urandom_range(0, 1)), $urandom_range(1, 6));
      for (int j = 0; j < 6; j++) begin
        bus8.A = 5'($urandom_range(0, 31));
        bus8.B = 5'($urandom_range(0, 31));
        tick();
        check_alu("rand");
      end
    end

    // Hold freezes result/flags while the counter still steps.
    goto_op(0);
    bus8.A = 5'd3;
    bus8.B = 5'd4;
    tick();
    model(op8, 3, 4, hr, hf);
    bus8.hold = 1'b1;
    bus8.A    = 5'd10;
    bus8.B    = 5'd20;
    tick();
    check("hold_res", bus8.result, hr);
    press(1'b0, 3);
    check("hold_res_after_step", bus8.result, hr);
    check("hold_flg_after_step", bus8.flags, hf);
    check("hold_op_stepped", bus8.currentOper, 1);
    bus8.hold = 1'b0;
    tick();
    check_alu("unhold");

    // Reset overrides hold.
    bus8.hold = 1'b1;
    do_reset(1'b1);
    bus8.hold = 1'b0;
    tick();
    check_alu("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_stepper.md
Name: alu_op_stepper

Overview:
- Parametrised successor to the button-stepped ALU controller.
- A debounced-press-driven operation counter selects one of NOPS ALU operations on BITS-wide operands. Result and NZCV flags are registered.
- Adds over the previous generation: configurable operand width and operation count, up/down stepping, a hold/freeze control, and a full flag set.
- Sits between board switches/buttons and the hex-display/LED drivers.

Parameters:
- BITS, 5, operand/result width (2..16)
- NOPS, 8, number of selectable operations (2..8); operation codes 0..NOPS-1

Ports:
- clk  input  1  system clock
- nreset  input  1  reset; synchronous, active-low
- noperSel  input  1  raw operation-step button, active-low (asynchronous to clk)
- dir  input  1  step direction: 0 = up, 1 = down
- hold  input  1  1 = freeze result and flags
- A  input  BITS  operand A
- B  input  BITS  operand B
- currentOper  output  4  current operation code, zero-extended
- result  output  BITS  registered ALU result
- flags  output  4  registered {N,Z,C,V}
- stepPulse  output  1  one-cycle strobe when the operation advances

Behaviour:
- Reset: on a clk rising edge with nreset=0:
  - currentOper=0, result=0, flags=4'b0000, stepPulse=0.
  - Both synchronizer flops and the edge-detect flop are set to 1 (button released), so release of reset with the button up never steps.
- Button path:
  - noperSel passes through a 2-flop synchronizer.
  - A press is a 1→0 transition of the synchronized level.
  - stepPulse is registered and high for exactly one cycle, two edges after the first sampled low (sampled at edge t, stepPulse high after edge t+2).
  - Holding the button produces exactly one pulse. A new pulse requires release (synchronized high for ≥1 cycle) and a new press.
- Operation counter:
  - Updates on the edge after stepPulse: currentOper advances by ±1 per dir, with dir sampled in the stepPulse cycle.
  - Up wraps NOPS-1→0. Down wraps 0→NOPS-1.
  - Codes ≥NOPS are never produced.
- Operation codes:
  - 0 ADD A+B
  - 1 SUB A-B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SHL A<<1
  - 6 SHR A>>1 (logical)
  - 7 NOT A
- Datapath: combinational from A, B, currentOper. result and flags are registered every cycle while hold=0 (1-cycle latency from operands/opcode). While hold=1, result and flags keep their values; the operation counter still steps.
- Flags:
  - N = result MSB.
  - Z = (result==0).
  - ADD: C = carry-out of bit BITS-1; V = operands same sign and result sign differs.
  - SUB: C = 1 when no borrow (A≥B unsigned); V = operand signs differ and result sign ≠ sign of A.
  - SHL: C = A[BITS-1]. SHR: C = A[0].
  - Logic ops and shifts: V=0. AND/OR/XOR/NOT: C=0.
- Arithmetic: modulo 2^BITS, unsigned storage, two's-complement interpretation for N/V.
- Simultaneous events:
  - nreset=0 overrides everything, including a pending stepPulse and hold.
  - A reset mid-press discards the press. If the button is still held after reset is released, no pulse occurs until it is released and pressed again.
- The hex/LED decode of result, flags and currentOper lives in downstream blocks, not here.

Test Plan:
- Reset with noperSel held low, then release reset: no stepPulse while the button stays low; currentOper=0, result=0, flags=0.
- BITS=5, NOPS=8, dir=0, 9 separate presses: currentOper 1,2,…,7,0,1. Each press gives exactly one stepPulse 2 cycles after the first low sample. A button held for 50 cycles gives one pulse.
- dir=1 from currentOper=0, one press: currentOper=7. With NOPS=5: currentOper=4.
- ADD: A=20, B=15 → result=3, flags N0 Z0 C1 V0. ADD: A=15, B=1 → result=16, N1 Z0 C0 V1.
- SUB: A=5, B=9 → result=28, N1 Z0 C0 V0. XOR: A=B=7 → result=0, Z=1. SHL: A=5'b10010 → result=5'b00100, C=1.
- hold=1, then change A/B and press the button: result/flags unchanged while currentOper steps. Drop hold: result reflects the new operation after 1 cycle.
